rv32i_hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB). It keeps a shadow scoreboard of in-flight destination registers and uses it to generate forwarding selects, load-use stalls, redirect flushes and data-memory wait freezes. The single-cycle-pipelined datapath has none of these and cannot run dependent code without software NOPs. The block sits beside the datapath and drives its pipeline-register enables and clears, the ALU-operand muxes and the regfile write-through bypass.

---
 rtl/rv32i_hazard_ctrl.sv | 160 ++++++++++++++++
 tb/tb_rv32i_hazard_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32I core: shadow scoreboard of in-flight
// destinations driving forwarding selects, load-use stalls, redirect flushes and memory-wait freezes.
module rv32i_hazard_ctrl #(
   parameter int FWD_EN   = 1,
   parameter int BR_STAGE = 2,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       id_rd,
   input  logic             id_regwrite,
   input  logic             id_load,
   input  logic             id_mem,
   input  logic             redirect,
   input  logic             dmem_ready,
   output logic             stall_pc,
   output logic             stall_if_id,
   output logic             bubble_id_ex,
   output logic             flush_if_id,
   output logic             flush_id_ex,
   output logic             flush_ex_mem,
   output logic             freeze,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             wb_byp_rs1,
   output logic             wb_byp_rs2,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic FWD_ON = (FWD_EN != 0);
   localparam logic BR_MEM = (BR_STAGE == 3);

   logic       ex_valid_reg, ex_regwrite_reg, ex_load_reg, ex_mem_reg;
   logic [4:0] ex_rd_reg, ex_rs1_reg, ex_rs2_reg;
   logic       mem_valid_reg, mem_regwrite_reg, mem_load_reg, mem_mem_reg;
   logic [4:0] mem_rd_reg;
   logic       wb_valid_reg, wb_regwrite_reg;
   logic [4:0] wb_rd_reg;
   logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;

   // x0 is hard-wired zero, so a producer targeting it never matches.
   function automatic logic prod_match(input logic v, input logic rw, input logic [4:0] rd,
                                       input logic [4:0] rx);
      return v & rw & (rd != 5'd0) & (rd == rx);
   endfunction

   logic [4:0] id_src [2];
   logic [4:0] ex_src [2];
   logic [1:0] id_use;
   logic [1:0] lu_src;
   logic [1:0] byp_src;
   logic [1:0] fwd_sel [2];

   assign id_src[0] = id_rs1;
   assign id_src[1] = id_rs2;
   assign ex_src[0] = ex_rs1_reg;
   assign ex_src[1] = ex_rs2_reg;
   assign id_use    = {id_use_rs2, id_use_rs1};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_opnd
         logic ex_hit_id, mem_hit_id, wb_hit_id, mem_hit_ex, wb_hit_ex;
         assign ex_hit_id  = prod_match(ex_valid_reg, ex_regwrite_reg, ex_rd_reg, id_src[gi]);
         assign mem_hit_id = prod_match(mem_valid_reg, mem_regwrite_reg, mem_rd_reg, id_src[gi]);
         assign wb_hit_id  = prod_match(wb_valid_reg, wb_regwrite_reg, wb_rd_reg, id_src[gi]);
         assign mem_hit_ex = prod_match(mem_valid_reg, mem_regwrite_reg, mem_rd_reg, ex_src[gi]);
         assign wb_hit_ex  = prod_match(wb_valid_reg, wb_regwrite_reg, wb_rd_reg, ex_src[gi]);

         // Without forwarding every EX or MEM producer must drain to WB before use.
         assign lu_src[gi]  = id_use[gi] & ((ex_hit_id & (ex_load_reg | !FWD_ON)) |
                                            (mem_hit_id & !FWD_ON));
         assign byp_src[gi] = id_valid & id_use[gi] & wb_hit_id;

         always_comb begin
            fwd_sel[gi] = 2'b00;
            if (FWD_ON) begin
               if (mem_hit_ex && !mem_load_reg)
                  fwd_sel[gi] = 2'b10;
               else if (wb_hit_ex)
                  fwd_sel[gi] = 2'b01;
            end
         end
      end
   endgenerate

   logic mem_wait, lu, frz, lu_act, redir_act;

   assign mem_wait  = mem_valid_reg & mem_mem_reg & !dmem_ready;
   assign lu        = id_valid & (|lu_src);
   assign frz       = !reset & mem_wait;
   // Redirect wins over a load-use stall: the stalled instruction is on the wrong path.
   assign lu_act    = !reset & lu & !redirect;
   assign redir_act = !reset & redirect & !frz;

   assign freeze       = frz;
   assign stall_pc     = frz | lu_act;
   assign stall_if_id  = frz | lu_act;
   assign bubble_id_ex = lu_act & !frz;
   assign flush_if_id  = redir_act;
   assign flush_id_ex  = redir_act;
   assign flush_ex_mem = redir_act & BR_MEM;
   assign fwd_a        = reset ? 2'b00 : fwd_sel[0];
   assign fwd_b        = reset ? 2'b00 : fwd_sel[1];
   assign wb_byp_rs1   = !reset & byp_src[0];
   assign wb_byp_rs2   = !reset & byp_src[1];
   assign stall_cnt    = stall_cnt_reg;
   assign flush_cnt    = flush_cnt_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ex_valid_reg     <= 1'b0;
         ex_regwrite_reg  <= 1'b0;
         ex_load_reg      <= 1'b0;
         ex_mem_reg       <= 1'b0;
         ex_rd_reg        <= 5'd0;
         ex_rs1_reg       <= 5'd0;
         ex_rs2_reg       <= 5'd0;
         mem_valid_reg    <= 1'b0;
         mem_regwrite_reg <= 1'b0;
         mem_load_reg     <= 1'b0;
         mem_mem_reg      <= 1'b0;
         mem_rd_reg       <= 5'd0;
         wb_valid_reg     <= 1'b0;
         wb_regwrite_reg  <= 1'b0;
         wb_rd_reg        <= 5'd0;
         stall_cnt_reg    <= '0;
         flush_cnt_reg    <= '0;
      end else begin
         if (!frz) begin
            wb_valid_reg     <= mem_valid_reg;
            wb_regwrite_reg  <= mem_regwrite_reg;
            wb_rd_reg        <= mem_rd_reg;
            mem_valid_reg    <= ex_valid_reg & !flush_ex_mem;
            mem_regwrite_reg <= ex_regwrite_reg;
            mem_load_reg     <= ex_load_reg;
            mem_mem_reg      <= ex_mem_reg;
            mem_rd_reg       <= ex_rd_reg;
            ex_valid_reg     <= id_valid & !bubble_id_ex & !flush_id_ex;
            ex_regwrite_reg  <= id_regwrite;
            ex_load_reg      <= id_load;
            ex_mem_reg       <= id_mem;
            ex_rd_reg        <= id_rd;
            ex_rs1_reg       <= id_rs1;
            ex_rs2_reg       <= id_rs2;
         end
         if (stall_pc && (stall_cnt_reg != '1))
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
         if (flush_id_ex && (flush_cnt_reg != '1))
            flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_rv32i_hazard_ctrl.sv
// Directed bench for rv32i_hazard_ctrl: one instance per parameter set (forwarding/EX-branch,
// MEM-branch, no-forwarding with 4-bit counters), all driven by the same ID stream.
module tb_rv32i_hazard_ctrl;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_load, id_mem, redirect, dmem_ready;
   logic [4:0] id_rs1, id_rs2, id_rd;

   always #5 clk = ~clk;

   // main: FWD_EN=1 BR_STAGE=2
   logic m_stall_pc, m_stall_if_id, m_bubble, m_fl_if, m_fl_id, m_fl_em, m_freeze, m_b1, m_b2;
   logic [1:0] m_fa, m_fb;
   logic [31:0] m_scnt, m_fcnt;
   // b3: FWD_EN=1 BR_STAGE=3
   logic b3_stall_pc, b3_stall_if_id, b3_bubble, b3_fl_if, b3_fl_id, b3_fl_em, b3_freeze, b3_b1, b3_b2;
   logic [1:0] b3_fa, b3_fb;
   logic [31:0] b3_scnt, b3_fcnt;
   // nf: FWD_EN=0 BR_STAGE=2 CNT_W=4
   logic nf_stall_pc, nf_stall_if_id, nf_bubble, nf_fl_if, nf_fl_id, nf_fl_em, nf_freeze, nf_b1, nf_b2;
   logic [1:0] nf_fa, nf_fb;
   logic [3:0] nf_scnt, nf_fcnt;

   rv32i_hazard_ctrl #(.FWD_EN(1), .BR_STAGE(2), .CNT_W(32)) u_dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_regwrite(id_regwrite),
      .id_load(id_load), .id_mem(id_mem), .redirect(redirect), .dmem_ready(dmem_ready),
      .stall_pc(m_stall_pc), .stall_if_id(m_stall_if_id), .bubble_id_ex(m_bubble),
      .flush_if_id(m_fl_if), .flush_id_ex(m_fl_id), .flush_ex_mem(m_fl_em), .freeze(m_freeze),
      .fwd_a(m_fa), .fwd_b(m_fb), .wb_byp_rs1(m_b1), .wb_byp_rs2(m_b2),
      .stall_cnt(m_scnt), .flush_cnt(m_fcnt));

   rv32i_hazard_ctrl #(.FWD_EN(1), .BR_STAGE(3), .CNT_W(32)) u_b3 (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_regwrite(id_regwrite),
      .id_load(id_load), .id_mem(id_mem), .redirect(redirect), .dmem_ready(dmem_ready),
      .stall_pc(b3_stall_pc), .stall_if_id(b3_stall_if_id), .bubble_id_ex(b3_bubble),
      .flush_if_id(b3_fl_if), .flush_id_ex(b3_fl_id), .flush_ex_mem(b3_fl_em), .freeze(b3_freeze),
      .fwd_a(b3_fa), .fwd_b(b3_fb), .wb_byp_rs1(b3_b1), .wb_byp_rs2(b3_b2),
      .stall_cnt(b3_scnt), .flush_cnt(b3_fcnt));

   rv32i_hazard_ctrl #(.FWD_EN(0), .BR_STAGE(2), .CNT_W(4)) u_nf (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_regwrite(id_regwrite),
      .id_load(id_load), .id_mem(id_mem), .redirect(redirect), .dmem_ready(dmem_ready),
      .stall_pc(nf_stall_pc), .stall_if_id(nf_stall_if_id), .bubble_id_ex(nf_bubble),
      .flush_if_id(nf_fl_if), .flush_id_ex(nf_fl_id), .flush_ex_mem(nf_fl_em), .freeze(nf_freeze),
      .fwd_a(nf_fa), .fwd_b(nf_fb), .wb_byp_rs1(nf_b1), .wb_byp_rs2(nf_b2),
      .stall_cnt(nf_scnt), .flush_cnt(nf_fcnt));

   typedef struct {
      logic v; logic [4:0] rs1; logic [4:0] rs2; logic u1; logic u2; logic [4:0] rd;
      logic rw; logic ld; logic mm; logic redir; logic rdy;
      logic st; logic bub; logic fl; logic flem3; logic frz; logic [1:0] fa; logic [1:0] fb;
      logic b1; logic b2; int scnt; int fcnt;
   } vec_t;

   int checks = 0;
   int failures = 0;
   vec_t tbl [19];

   function automatic vec_t mk(input int v, input int rs1, input int rs2, input int u1, input int u2,
                               input int rd, input int rw, input int ld, input int mm, input int redir,
                               input int rdy, input int st, input int bub, input int fl, input int flem3,
                               input int frz, input int fa, input int fb, input int b1, input int b2,
                               input int scnt, input int fcnt);
      vec_t r;
      r.v = (v != 0); r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.u1 = (u1 != 0); r.u2 = (u2 != 0);
      r.rd = 5'(rd); r.rw = (rw != 0); r.ld = (ld != 0); r.mm = (mm != 0);
      r.redir = (redir != 0); r.rdy = (rdy != 0);
      r.st = (st != 0); r.bub = (bub != 0); r.fl = (fl != 0); r.flem3 = (flem3 != 0);
      r.frz = (frz != 0); r.fa = 2'(fa); r.fb = 2'(fb); r.b1 = (b1 != 0); r.b2 = (b2 != 0);
      r.scnt = scnt; r.fcnt = fcnt;
      return r;
   endfunction

   task automatic chk(input string nm, input int cyc, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, got, exp);
      end
   endtask

   task automatic set_in(input int v, input int rs1, input int rs2, input int u1, input int u2,
                         input int rd, input int rw, input int ld, input int mm, input int redir,
                         input int rdy);
      id_valid = (v != 0); id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
      id_use_rs1 = (u1 != 0); id_use_rs2 = (u2 != 0); id_rd = 5'(rd);
      id_regwrite = (rw != 0); id_load = (ld != 0); id_mem = (mm != 0);
      redirect = (redir != 0); dmem_ready = (rdy != 0);
   endtask

   task automatic step(input int v, input int rs1, input int rs2, input int u1, input int u2,
                       input int rd, input int rw, input int ld, input int mm, input int redir,
                       input int rdy);
      @(negedge clk);
      set_in(v, rs1, rs2, u1, u2, rd, rw, ld, mm, redir, rdy);
      #1;
   endtask

   task automatic do_reset(input int tag);
      @(negedge clk);
      reset = 1'b1;
      set_in(1, 5, 5, 1, 1, 6, 1, 1, 1, 1, 0);
      #1;
      chk("rst_stall_pc", tag, 32'(m_stall_pc), 32'(0));
      chk("rst_stall_if_id", tag, 32'(m_stall_if_id), 32'(0));
      chk("rst_bubble", tag, 32'(m_bubble), 32'(0));
      chk("rst_flush_if_id", tag, 32'(m_fl_if), 32'(0));
      chk("rst_flush_id_ex", tag, 32'(m_fl_id), 32'(0));
      chk("rst_b3_flush_ex_mem", tag, 32'(b3_fl_em), 32'(0));
      chk("rst_freeze", tag, 32'(m_freeze), 32'(0));
      chk("rst_fwd", tag, 32'({m_fa, m_fb}), 32'(0));
      chk("rst_byp", tag, 32'({m_b1, m_b2}), 32'(0));
      chk("rst_stall_cnt", tag, m_scnt, 32'(0));
      chk("rst_flush_cnt", tag, m_fcnt, 32'(0));
      @(negedge clk);
      reset = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
   endtask

   initial begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      //              v rs1 rs2 u1 u2 rd rw ld mm rd rdy | st bu fl f3 fz fa fb b1 b2 sc fc
      tbl[0]  = mk(1,  1,  0, 1, 0,  5, 1, 1, 1, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); // lw x5
      tbl[1]  = mk(1,  5,  2, 1, 1,  6, 1, 0, 0, 0, 1,   1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); // add x6 load-use
      tbl[2]  = mk(1,  5,  2, 1, 1,  6, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      tbl[3]  = mk(1,  6,  5, 1, 1,  8, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0); // sub x8
      tbl[4]  = mk(1,  0,  0, 1, 0,  3, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 2, 0, 0, 0, 1, 0); // addi x3
      tbl[5]  = mk(1,  1,  2, 1, 1,  3, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); // add x3
      tbl[6]  = mk(1,  4,  3, 1, 1,  9, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); // consumer x3
      tbl[7]  = mk(1,  1,  1, 1, 1,  0, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 2, 0, 0, 1, 0); // add x0
      tbl[8]  = mk(1,  1,  0, 1, 0,  0, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); // addi x0
      tbl[9]  = mk(1,  1,  0, 1, 1, 10, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0); // consumer x0
      tbl[10] = mk(1,  0, 10, 1, 1, 11, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      tbl[11] = mk(1,  1,  0, 1, 0, 12, 1, 1, 1, 0, 1,   0, 0, 0, 0, 0, 0, 2, 0, 0, 1, 0); // lw x12
      tbl[12] = mk(1, 12,  0, 1, 0, 13, 1, 0, 0, 1, 1,   0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0); // redirect+lu
      tbl[13] = mk(1,  1,  2, 1, 1,  0, 0, 0, 1, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1); // sw
      tbl[14] = mk(0,  0,  0, 0, 0,  0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
      tbl[15] = mk(0,  0,  0, 0, 0,  0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1); // freeze
      tbl[16] = mk(0,  0,  0, 0, 0,  0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 1, 0, 0, 0, 0, 2, 1);
      tbl[17] = mk(0,  0,  0, 0, 0,  0, 0, 0, 0, 1, 0,   1, 0, 0, 0, 1, 0, 0, 0, 0, 3, 1);
      tbl[18] = mk(0,  0,  0, 0, 0,  0, 0, 0, 0, 1, 1,   0, 0, 1, 1, 0, 0, 0, 0, 0, 4, 1); // released

      #1;
      do_reset(-1);

      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         set_in(int'(tbl[i].v), int'(tbl[i].rs1), int'(tbl[i].rs2), int'(tbl[i].u1), int'(tbl[i].u2),
                int'(tbl[i].rd), int'(tbl[i].rw), int'(tbl[i].ld), int'(tbl[i].mm),
                int'(tbl[i].redir), int'(tbl[i].rdy));
         #1;
         chk("stall_pc", i, 32'(m_stall_pc), 32'(tbl[i].st));
         chk("stall_if_id", i, 32'(m_stall_if_id), 32'(tbl[i].st));
         chk("bubble_id_ex", i, 32'(m_bubble), 32'(tbl[i].bub));
         chk("flush_if_id", i, 32'(m_fl_if), 32'(tbl[i].fl));
         chk("flush_id_ex", i, 32'(m_fl_id), 32'(tbl[i].fl));
         chk("flush_ex_mem_br2", i, 32'(m_fl_em), 32'(0));
         chk("flush_ex_mem_br3", i, 32'(b3_fl_em), 32'(tbl[i].flem3));
         chk("freeze", i, 32'(m_freeze), 32'(tbl[i].frz));
         chk("fwd_a", i, 32'(m_fa), 32'(tbl[i].fa));
         chk("fwd_b", i, 32'(m_fb), 32'(tbl[i].fb));
         chk("wb_byp_rs1", i, 32'(m_b1), 32'(tbl[i].b1));
         chk("wb_byp_rs2", i, 32'(m_b2), 32'(tbl[i].b2));
         chk("stall_cnt", i, m_scnt, 32'(tbl[i].scnt));
         chk("flush_cnt", i, m_fcnt, 32'(tbl[i].fcnt));
         chk("nofwd_fwd", i, 32'({nf_fa, nf_fb}), 32'(0));
         $display("vec %0d: stall=%0b bubble=%0b flush=%0b freeze=%0b fwd_a=%0d fwd_b=%0d scnt=%0d fcnt=%0d",
                  i, m_stall_pc, m_bubble, m_fl_id, m_freeze, m_fa, m_fb, m_scnt, m_fcnt);
      end

      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      chk("stall_cnt_end", 19, m_scnt, 32'(4));
      chk("flush_cnt_end", 19, m_fcnt, 32'(2));

      // No-forwarding instance: MEM producer and EX non-load producer both stall.
      do_reset(-2);
      step(1, 1, 2, 1, 1, 4, 1, 0, 0, 0, 1);
      chk("nf_idle_stall", 100, 32'(nf_stall_pc), 32'(0));
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      step(1, 4, 0, 1, 0, 5, 1, 0, 0, 0, 1);
      chk("nf_mem_stall", 102, 32'(nf_stall_pc), 32'(1));
      chk("nf_mem_bubble", 102, 32'(nf_bubble), 32'(1));
      chk("nf_fwd", 102, 32'({nf_fa, nf_fb}), 32'(0));
      chk("fwd_mem_nostall", 102, 32'(m_stall_pc), 32'(0));
      $display("nofwd mem-hazard: nf_stall=%0b main_stall=%0b", nf_stall_pc, m_stall_pc);
      step(1, 4, 0, 1, 0, 5, 1, 0, 0, 0, 1);
      chk("nf_release", 103, 32'(nf_stall_pc), 32'(0));
      chk("nf_wb_byp", 103, 32'(nf_b1), 32'(1));
      chk("nf_fwd", 103, 32'({nf_fa, nf_fb}), 32'(0));
      step(1, 1, 1, 1, 1, 6, 1, 0, 0, 0, 1);
      chk("nf_fwd", 104, 32'({nf_fa, nf_fb}), 32'(0));
      step(1, 0, 6, 0, 1, 7, 1, 0, 0, 0, 1);
      chk("nf_ex_stall", 105, 32'(nf_stall_pc), 32'(1));
      chk("fwd_ex_nostall", 105, 32'(m_stall_pc), 32'(0));
      chk("nf_fwd", 105, 32'({nf_fa, nf_fb}), 32'(0));
      $display("nofwd ex-hazard: nf_stall=%0b main_stall=%0b", nf_stall_pc, m_stall_pc);

      // Long freeze: 4-bit counter saturates, then reset lands mid-freeze.
      do_reset(-3);
      step(1, 1, 2, 1, 1, 0, 0, 0, 1, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 20; i++) begin
         step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
         if (i == 0) begin
            chk("sat_freeze_main", 200, 32'(m_freeze), 32'(1));
            chk("sat_freeze_nf", 200, 32'(nf_freeze), 32'(1));
         end
      end
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("sat_stall_cnt_w32", 221, m_scnt, 32'(20));
      chk("sat_stall_cnt_w4", 221, 32'(nf_scnt), 32'(15));
      chk("sat_still_frozen", 221, 32'(m_freeze), 32'(1));
      $display("saturation: main_scnt=%0d nf_scnt=%0d", m_scnt, nf_scnt);

      @(negedge clk);
      reset = 1'b1;
      set_in(1, 5, 5, 1, 1, 6, 1, 1, 1, 1, 0);
      #1;
      chk("midfrz_freeze", 222, 32'(m_freeze), 32'(0));
      chk("midfrz_stall", 222, 32'(m_stall_pc), 32'(0));
      chk("midfrz_flush", 222, 32'(m_fl_if), 32'(0));
      chk("midfrz_scnt", 222, m_scnt, 32'(0));
      chk("midfrz_nf_scnt", 222, 32'(nf_scnt), 32'(0));
      chk("midfrz_nf_freeze", 222, 32'(nf_freeze), 32'(0));
      @(negedge clk);
      reset = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("post_rst_freeze", 223, 32'(m_freeze), 32'(0));
      chk("post_rst_stall", 223, 32'(m_stall_pc), 32'(0));
      chk("post_rst_scnt", 223, m_scnt, 32'(0));
      $display("post-reset: freeze=%0b scnt=%0d", m_freeze, m_scnt);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
